// File: rtl/fusion_window_queue.sv
// Instruction queue feeding the fusion unit: buffers 16-bit fetch words and exposes a head/head+1 window.
// Optional FUSION_QUEUE_STATS_EN adds fused-pair and fetch-stall counters.
module fusion_window_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_inst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      inst1,
  output logic [15:0]      inst2,
  output logic             inst1_valid,
  output logic             inst2_valid,
  input  logic [1:0]       pop_cnt,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy,
  output logic             underflow_err
`ifdef FUSION_QUEUE_STATS_EN
  ,
  output logic [31:0]      pair_pop_count,
  output logic [31:0]      stall_count
`endif
);

  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_occ;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop_req;
  logic             w_pop_legal;
  logic [1:0]       w_pop_amt;
  logic [CNT_W-1:0] w_pop_cnt_ext;
  logic [PTR_W-1:0] w_rd_ptr_p1;

  // Readiness uses pre-pop occupancy: a pop into a full queue frees space only next cycle
  assign in_ready      = (r_occ < CNT_W'(DEPTH));
  assign w_push        = in_valid && in_ready && !flush;
  assign w_pop_cnt_ext = {{(CNT_W-2){1'b0}}, pop_cnt};
  assign w_pop_req     = (pop_cnt != 2'd0);
  assign w_pop_legal   = w_pop_req && (pop_cnt != 2'd3) && (w_pop_cnt_ext <= r_occ);
  assign w_pop_amt     = w_pop_legal ? pop_cnt : 2'd0;

  // Pointer, occupancy and error-pulse state; rst beats flush beats normal traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_occ       <= {CNT_W{1'b0}};
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_occ       <= {CNT_W{1'b0}};
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr    <= r_rd_ptr + PTR_W'(w_pop_amt);
      r_occ       <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop_amt);
      r_underflow <= w_pop_req && !w_pop_legal;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= in_inst;
    end
  end

  // Window slot 1 wraps naturally through PTR_W overflow
  assign w_rd_ptr_p1   = r_rd_ptr + PTR_W'(1);
  assign inst1_valid   = (r_occ >= CNT_W'(1));
  assign inst2_valid   = (r_occ >= CNT_W'(2));
  assign inst1         = inst1_valid ? r_mem[r_rd_ptr]    : 16'h0000;
  assign inst2         = inst2_valid ? r_mem[w_rd_ptr_p1] : 16'h0000;
  assign occupancy     = r_occ;
  assign underflow_err = r_underflow;

`ifdef FUSION_QUEUE_STATS_EN
  logic [31:0] r_pair_pop_count;
  logic [31:0] r_stall_count;

  // Statistics survive flush; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pair_pop_count <= 32'd0;
      r_stall_count    <= 32'd0;
    end else begin
      if (w_pop_legal && (pop_cnt == 2'd2) && !flush) begin
        r_pair_pop_count <= r_pair_pop_count + 32'd1;
      end
      if (in_valid && !in_ready) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign pair_pop_count = r_pair_pop_count;
  assign stall_count    = r_stall_count;
`endif

endmodule

// File: tb/tb_fusion_window_queue.sv
// Directed bench for fusion_window_queue with a queue-based scoreboard of expected window contents.
module tb_fusion_window_queue;

  logic        clk;
  logic        rst;
  logic [15:0] in_inst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inst1;
  logic [15:0] inst2;
  logic        inst1_valid;
  logic        inst2_valid;
  logic [1:0]  pop_cnt;
  logic        flush;
  logic [3:0]  occupancy;
  logic        underflow_err;
`ifdef FUSION_QUEUE_STATS_EN
  logic [31:0] pair_pop_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb [$];
  logic        exp_err;
  int unsigned exp_pair;
  int unsigned exp_stall;

  fusion_window_queue #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_inst       (in_inst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inst1         (inst1),
    .inst2         (inst2),
    .inst1_valid   (inst1_valid),
    .inst2_valid   (inst2_valid),
    .pop_cnt       (pop_cnt),
    .flush         (flush),
    .occupancy     (occupancy),
    .underflow_err (underflow_err)
`ifdef FUSION_QUEUE_STATS_EN
    ,
    .pair_pop_count(pair_pop_count),
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int n;
    n = sb.size();
    chk("occupancy",   32'(occupancy),   32'(n));
    chk("in_ready",    32'(in_ready),    32'(n < 8));
    chk("inst1_valid", 32'(inst1_valid), 32'(n >= 1));
    chk("inst2_valid", 32'(inst2_valid), 32'(n >= 2));
    chk("inst1",       32'(inst1),       (n >= 1) ? 32'(sb[0]) : 32'd0);
    chk("inst2",       32'(inst2),       (n >= 2) ? 32'(sb[1]) : 32'd0);
    chk("underflow",   32'(underflow_err), 32'(exp_err));
`ifdef FUSION_QUEUE_STATS_EN
    chk("pair_pop_count", pair_pop_count, exp_pair);
    chk("stall_count",    stall_count,    exp_stall);
`endif
  endtask

  // One clock of stimulus; the scoreboard is advanced from the inputs, then the DUT is compared after the edge
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic [1:0] pc, input logic fl);
    int n;
    bit rdy;
    bit legal;
    bit psh;
    rst = r; in_valid = v; in_inst = d; pop_cnt = pc; flush = fl;
    n     = sb.size();
    rdy   = (n < 8);
    legal = ((pc == 2'd1) || (pc == 2'd2)) && (int'(pc) <= n);
    psh   = v && rdy && !fl;
    if (r) begin
      sb.delete();
      exp_err = 1'b0; exp_pair = 0; exp_stall = 0;
    end else begin
      if (v && !rdy) exp_stall++;
      if (fl) begin
        sb.delete();
        exp_err = 1'b0;
      end else begin
        exp_err = (pc != 2'd0) && !legal;
        if (legal) begin
          repeat (int'(pc)) void'(sb.pop_front());
          if (pc == 2'd2) exp_pair++;
        end
        if (psh) sb.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 16'h0000; pop_cnt = 2'd0; flush = 1'b0;
    exp_err = 1'b0; exp_pair = 0; exp_stall = 0;

    // Reset and idle
    step(1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 2'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("reset_inst1", 32'(inst1), 32'h0000);
    chk("reset_ready", 32'(in_ready), 32'd1);

    // Two-entry window then fused pop
    step(1'b0, 1'b1, 16'h7A05, 2'd0, 1'b0);
    step(1'b0, 1'b1, 16'hF605, 2'd0, 1'b0);
    chk("pair_inst1", 32'(inst1), 32'h7A05);
    chk("pair_inst2", 32'(inst2), 32'hF605);
    step(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);
    chk("pair_drained", 32'(occupancy), 32'd0);

    // Fill to full, blocked push, pop frees space a cycle later
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i), 2'd0, 1'b0);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd8);
    step(1'b0, 1'b1, 16'h1008, 2'd0, 1'b0);
`ifdef FUSION_QUEUE_STATS_EN
    chk("stall_one", stall_count, 32'd1);
`endif
    step(1'b0, 1'b1, 16'h1008, 2'd1, 1'b0);
    step(1'b0, 1'b1, 16'h1008, 2'd0, 1'b0);
    chk("refill_occ", 32'(occupancy), 32'd8);
    repeat (4) step(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);

    // Wrap from rd_ptr=7 after zeroing pointers with flush
    step(1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i), 2'd0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 2'd0, 1'b0);
    chk("wrap_inst1", 32'(inst1), 32'h1007);
    chk("wrap_inst2", 32'(inst2), 32'h2222);
    step(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);
    chk("wrap_empty", 32'(occupancy), 32'd0);

    // Illegal pops: oversized with concurrent push, then pop_cnt=3, then pop on empty
    step(1'b0, 1'b1, 16'h5555, 2'd0, 1'b0);
    step(1'b0, 1'b1, 16'h3333, 2'd2, 1'b0);
    chk("uf_pulse", 32'(underflow_err), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);
    chk("uf_clear", 32'(underflow_err), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 2'd3, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0);

    // Flush at occupancy 5 discards the concurrent push and pop
    repeat (4) step(1'b0, 1'b1, 16'hA0A0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 16'hB0B0, 2'd0, 1'b0);
    chk("pre_flush_occ", 32'(occupancy), 32'd5);
    step(1'b0, 1'b1, 16'h4444, 2'd1, 1'b1);
    step(1'b0, 1'b1, 16'h6666, 2'd0, 1'b0);
    chk("post_flush_inst1", 32'(inst1), 32'h6666);

    // Reset while pushing
    step(1'b0, 1'b1, 16'h7777, 2'd0, 1'b0);
    step(1'b1, 1'b1, 16'h8888, 2'd1, 1'b0);
    chk("rst_mid_occ", 32'(occupancy), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
